dual_crack_ctrl: RTL and testbench
==================================

Name: dual_crack_ctrl

Overview:
- Scheduler that runs two crack cores in parallel on one ciphertext.
- Core 0 searches even keys and core 1 searches odd keys; that split is wired inside the cores and this block does not control it.
- The block copies the ciphertext from the shared ct_mem into both cores' private CT copies, starts both cores in the same cycle, and takes the first valid key found.
- When one core finds a key, the block aborts the other core and reports the result through a rdy/en handshake to the top level.

Parameters:
- KEY_W, 24, key width.
- ADDR_W, 8, ct_mem and copy address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- en  in  1  start request; accepted only while rdy=1
- rdy  out  1  ready for a new request
- key  out  KEY_W  found key
- key_valid  out  1  key is meaningful
- ct_addr  out  ADDR_W  read address to shared ct_mem
- ct_rddata  in  8  ct_mem q; valid 1 cycle after ct_addr is presented
- cp_addr  out  ADDR_W  write address, broadcast to both private CT copies
- cp_wrdata  out  8  write data
- cp_wren  out  1  write enable
- c0_en, c1_en  out  1  core start pulses
- c0_rdy, c1_rdy  in  1  core ready
- c0_key, c1_key  in  KEY_W  core results
- c0_key_valid, c1_key_valid  in  1  core result valid
- core_rst_n  out  1  core reset, = rst_n AND NOT abort

Behaviour:
- Reset values: state IDLE, rdy=1, key=0, key_valid=0, ct_addr=0, cp_wren=0, cp_addr=0, cp_wrdata=0, c0_en=0, c1_en=0, abort=0.
- Reset mid-operation returns to IDLE and holds core_rst_n low while rst_n is low.
- States: IDLE, COPY, START, RUN, ABORT, DONE.
- IDLE / DONE:
  - rdy=1.
  - en=1 → clear key and key_valid, set rd_ptr=0 and wr_ptr=0, go to COPY.
  - key and key_valid hold in DONE until the next accepted en.
- COPY:
  - rdy=0; ct_addr=rd_ptr, and rd_ptr increments every cycle.
  - From the 2nd COPY cycle on: cp_wren=1, cp_addr=wr_ptr, cp_wrdata=ct_rddata, wr_ptr increments.
  - The first returned byte (address 0) is the length L; latch it and also write it to the copies.
  - Exit when the write of address L occurs.
  - Exactly L+1 writes, addresses 0..L, in ascending order, no gaps or duplicates.
  - L=0 gives a single write; L=255 gives 256 writes with no wrap.
  - Reads beyond L may be issued; their data is discarded.
- START:
  - Wait until c0_rdy=1 and c1_rdy=1, then pulse c0_en=1 and c1_en=1 for exactly one cycle, same cycle.
  - Go to RUN.
- RUN:
  - Core rdy is ignored in the first RUN cycle.
  - Thereafter, a core whose rdy=1 is finished; record a done flag per core.
  - Any finished core with key_valid=1 → latch that core's key and set key_valid=1.
  - If both are valid in the same cycle, core 0 wins.
  - If the other core is still running, go to ABORT; otherwise go to DONE.
  - Both cores finished with neither valid → key_valid=0, go to DONE.
  - One core finished invalid → keep waiting for the other.
- ABORT: abort=1 for exactly one cycle, so core_rst_n=0, then go to DONE.
- en while rdy=0 is ignored.
- Only one outstanding request at a time.
- Latency: en accepted at cycle 0; COPY runs cycles 1..L+2; START is entered at cycle L+3 and pulses the cores then if both are ready.

Test Plan:
- ct_mem L=3, bytes {03,A1,B2,C3}; en pulse → cp writes (0,03),(1,A1),(2,B2),(3,C3) in consecutive cycles; c0_en and c1_en pulse together once; rdy=0 throughout.
- Core 1 returns key 0x00002B valid at cycle X while core 0 is still busy → key=0x00002B, key_valid=1, core_rst_n low exactly 1 cycle, rdy=1 next.
- Both cores finish in the same cycle, valid, keys 0x000010 and 0x000011 → key=0x000010; no abort pulse.
- Core 0 finishes invalid, core 1 finishes invalid 50 cycles later → key_valid=0, key=0, DONE.
- L=0 → exactly one cp write (0,00); L=255 → 256 writes, last to address 255.
- rst_n low during COPY at write 5 → next cycle IDLE, rdy=1, cp_wren=0; a new en restarts the copy from address 0.

Source files
------------

// File: rtl/dual_crack_ctrl.sv
// Dual crack-core scheduler: copies the ciphertext from ct_mem into both cores'
// private copies, starts both cores together, keeps the first valid key and
// aborts whichever core is still searching.
module dual_crack_ctrl #(
    parameter int unsigned KEY_W  = 24,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    output logic [KEY_W-1:0]  key,
    output logic              key_valid,
    output logic [ADDR_W-1:0] ct_addr,
    input  logic [7:0]        ct_rddata,
    output logic [ADDR_W-1:0] cp_addr,
    output logic [7:0]        cp_wrdata,
    output logic              cp_wren,
    output logic              c0_en,
    output logic              c1_en,
    input  logic              c0_rdy,
    input  logic              c1_rdy,
    input  logic [KEY_W-1:0]  c0_key,
    input  logic [KEY_W-1:0]  c1_key,
    input  logic              c0_key_valid,
    input  logic              c1_key_valid,
    output logic              core_rst_n
);

    typedef enum logic [2:0] {
        StIdle,
        StCopy,
        StStart,
        StRun,
        StAbort,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [7:0]         len_q, len_d;
    logic               copy_wr_q, copy_wr_d;   // read data is valid from the 2nd COPY cycle
    logic               run_first_q, run_first_d;
    logic               c0_done_q, c0_done_d;
    logic               c1_done_q, c1_done_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               key_valid_q, key_valid_d;
    logic               abort;
    logic [7:0]         len_cur;
    logic               done0, done1;

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            len_q       <= '0;
            copy_wr_q   <= 1'b0;
            run_first_q <= 1'b0;
            c0_done_q   <= 1'b0;
            c1_done_q   <= 1'b0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            len_q       <= len_d;
            copy_wr_q   <= copy_wr_d;
            run_first_q <= run_first_d;
            c0_done_q   <= c0_done_d;
            c1_done_q   <= c1_done_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
        end
    end

    // Next-state logic and decoded outputs.
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        len_d       = len_q;
        copy_wr_d   = copy_wr_q;
        run_first_d = run_first_q;
        c0_done_d   = c0_done_q;
        c1_done_d   = c1_done_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        rdy         = 1'b0;
        ct_addr     = '0;
        cp_addr     = '0;
        cp_wrdata   = '0;
        cp_wren     = 1'b0;
        c0_en       = 1'b0;
        c1_en       = 1'b0;
        abort       = 1'b0;
        // The length byte is used in the same cycle it arrives.
        len_cur     = (wr_ptr_q == '0) ? ct_rddata : len_q;
        done0       = c0_done_q | c0_rdy;
        done1       = c1_done_q | c1_rdy;

        unique case (state_q)
            StIdle, StDone: begin
                rdy = 1'b1;
                if (en) begin
                    key_d       = '0;
                    key_valid_d = 1'b0;
                    rd_ptr_d    = '0;
                    wr_ptr_d    = '0;
                    copy_wr_d   = 1'b0;
                    state_d     = StCopy;
                end
            end
            StCopy: begin
                ct_addr   = rd_ptr_q;
                rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
                copy_wr_d = 1'b1;
                if (copy_wr_q) begin
                    cp_wren   = 1'b1;
                    cp_addr   = wr_ptr_q;
                    cp_wrdata = ct_rddata;
                    wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
                    if (wr_ptr_q == '0) len_d = ct_rddata;
                    if (wr_ptr_q == ADDR_W'(len_cur)) state_d = StStart;
                end
            end
            StStart: begin
                if (c0_rdy && c1_rdy) begin
                    c0_en       = 1'b1;
                    c1_en       = 1'b1;
                    run_first_d = 1'b1;
                    c0_done_d   = 1'b0;
                    c1_done_d   = 1'b0;
                    state_d     = StRun;
                end
            end
            StRun: begin
                run_first_d = 1'b0;
                // Core rdy may still reflect the pre-start idle level in the first cycle.
                if (!run_first_q) begin
                    c0_done_d = done0;
                    c1_done_d = done1;
                    if (c0_rdy && c0_key_valid) begin
                        key_d       = c0_key;
                        key_valid_d = 1'b1;
                        state_d     = done1 ? StDone : StAbort;
                    end else if (c1_rdy && c1_key_valid) begin
                        key_d       = c1_key;
                        key_valid_d = 1'b1;
                        state_d     = done0 ? StDone : StAbort;
                    end else if (done0 && done1) begin
                        key_valid_d = 1'b0;
                        state_d     = StDone;
                    end
                end
            end
            StAbort: begin
                abort   = 1'b1;
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    assign key        = key_q;
    assign key_valid  = key_valid_q;
    assign core_rst_n = rst_n & ~abort;

endmodule

// File: tb/tb_dual_crack_ctrl.sv
// Bench for dual_crack_ctrl: ct_mem and two behavioural crack cores with
// programmable latency/result; expected outcomes come from a first-finisher model.
module tb_dual_crack_ctrl;

    localparam int KEY_W  = 24;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              rdy;
    logic [KEY_W-1:0]  key;
    logic              key_valid;
    logic [ADDR_W-1:0] ct_addr;
    logic [7:0]        ct_rddata = 8'h00;
    logic [ADDR_W-1:0] cp_addr;
    logic [7:0]        cp_wrdata;
    logic              cp_wren;
    logic              c0_en, c1_en;
    logic              c0_rdy, c1_rdy;
    logic [KEY_W-1:0]  c0_key = '0, c1_key = '0;
    logic              c0_key_valid = 1'b0, c1_key_valid = 1'b0;
    logic              core_rst_n;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    logic [7:0] mem [256];

    dual_crack_ctrl #(.KEY_W(KEY_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .rdy          (rdy),
        .key          (key),
        .key_valid    (key_valid),
        .ct_addr      (ct_addr),
        .ct_rddata    (ct_rddata),
        .cp_addr      (cp_addr),
        .cp_wrdata    (cp_wrdata),
        .cp_wren      (cp_wren),
        .c0_en        (c0_en),
        .c1_en        (c1_en),
        .c0_rdy       (c0_rdy),
        .c1_rdy       (c1_rdy),
        .c0_key       (c0_key),
        .c1_key       (c1_key),
        .c0_key_valid (c0_key_valid),
        .c1_key_valid (c1_key_valid),
        .core_rst_n   (core_rst_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) ct_rddata <= mem[ct_addr];

    // Core models: after a start pulse, rdy drops for lat+1 cycles, then the
    // programmed result appears. Core reset returns a core to idle.
    int              c0_lat = 1, c1_lat = 1, c0_cnt = 0, c1_cnt = 0;
    logic            c0_pvalid = 1'b0, c1_pvalid = 1'b0;
    logic [KEY_W-1:0] c0_pkey = '0, c1_pkey = '0;
    logic            c0_busy = 1'b0, c1_busy = 1'b0;
    logic            c0_rdy_m = 1'b1, c1_rdy_m = 1'b1;
    logic            c1_hold = 1'b0;

    assign c0_rdy = c0_rdy_m;
    assign c1_rdy = c1_rdy_m & ~c1_hold;

    always @(posedge clk) begin
        if (!core_rst_n) begin
            c0_rdy_m <= 1'b1; c0_key_valid <= 1'b0; c0_busy <= 1'b0;
        end else if (c0_en) begin
            c0_rdy_m <= 1'b0; c0_key_valid <= 1'b0; c0_busy <= 1'b1; c0_cnt <= c0_lat;
        end else if (c0_busy) begin
            if (c0_cnt == 0) begin
                c0_rdy_m <= 1'b1; c0_key <= c0_pkey; c0_key_valid <= c0_pvalid;
                c0_busy <= 1'b0;
            end else c0_cnt <= c0_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (!core_rst_n) begin
            c1_rdy_m <= 1'b1; c1_key_valid <= 1'b0; c1_busy <= 1'b0;
        end else if (c1_en) begin
            c1_rdy_m <= 1'b0; c1_key_valid <= 1'b0; c1_busy <= 1'b1; c1_cnt <= c1_lat;
        end else if (c1_busy) begin
            if (c1_cnt == 0) begin
                c1_rdy_m <= 1'b1; c1_key <= c1_pkey; c1_key_valid <= c1_pvalid;
                c1_busy <= 1'b0;
            end else c1_cnt <= c1_cnt - 1;
        end
    end

    // Monitor: logs copy writes, start pulses and abort cycles at the negedge.
    logic       mon_on = 1'b0, mon_clr = 1'b0;
    int         wa [$];
    logic [7:0] wd [$];
    int         wc [$];
    int         c0n = 0, c1n = 0, c0c = 0, c1c = 0, abn = 0;

    always @(negedge clk) begin
        if (mon_clr) begin
            wa.delete(); wd.delete(); wc.delete();
            c0n = 0; c1n = 0; c0c = -1; c1c = -1; abn = 0;
        end else if (mon_on) begin
            if (cp_wren) begin wa.push_back(int'(cp_addr)); wd.push_back(cp_wrdata);
                wc.push_back(cyc); end
            if (c0_en) begin c0n++; c0c = cyc; end
            if (c1_en) begin c1n++; c1c = cyc; end
            if (rst_n && !core_rst_n) abn++;
        end
    end

    task automatic fill_mem(input int len);
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'(len);
    endtask

    // One full request: expectation comes from which core finishes first and whether valid.
    task automatic run_op(input string nm, input int len, input int h, input bit noisy,
                          input int d0, input bit v0, input logic [KEY_W-1:0] k0,
                          input int d1, input bit v1, input logic [KEY_W-1:0] k1);
        int t0, s, tdone, n, bound, bad, fin, edone;
        logic [KEY_W-1:0] ek;
        bit ev, eab;
        c0_lat = d0; c0_pvalid = v0; c0_pkey = k0;
        c1_lat = d1; c1_pvalid = v1; c1_pkey = k1;
        if (d0 <= d1 && v0)      begin ek = k0; ev = 1; eab = (d0 < d1); fin = d0; end
        else if (d1 <= d0 && v1) begin ek = k1; ev = 1; eab = (d1 < d0); fin = d1; end
        else if (v0)             begin ek = k0; ev = 1; eab = 0; fin = d0; end
        else if (v1)             begin ek = k1; ev = 1; eab = 0; fin = d1; end
        else begin ek = '0; ev = 0; eab = 0; fin = (d0 > d1) ? d0 : d1; end

        @(posedge clk); #1; mon_clr = 1'b1;
        @(posedge clk); #1; mon_clr = 1'b0; mon_on = 1'b1;
        tests_run++;
        if (rdy !== 1'b1) begin
            tests_failed++; $display("FAIL %s idle_rdy: got %b expected 1", nm, rdy);
        end
        c1_hold = (h > 0);
        t0 = cyc; en = 1'b1;
        s = t0 + len + 3 + h;
        edone = s + 2 + fin + 1 + int'(eab);
        @(posedge clk); #1; en = 1'b0;
        bound = len + h + d0 + d1 + 40;
        n = 0;
        while (rdy !== 1'b1 && n < bound) begin
            if (c1_hold && cyc >= s) c1_hold = 1'b0;
            if (noisy) en = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        en = 1'b0; c1_hold = 1'b0;
        tdone = cyc;
        @(posedge clk); #1; mon_on = 1'b0;

        tests_run++;
        if (n >= bound) begin
            tests_failed++; $display("FAIL %s timeout: rdy stuck low after %0d cycles", nm, n);
        end
        tests_run++;
        if (wa.size() !== len + 1) begin
            tests_failed++;
            $display("FAIL %s write_count: got %0d expected %0d", nm, wa.size(), len + 1);
        end
        bad = -1;
        for (int i = 0; i < wa.size() && i <= len; i++)
            if (bad < 0 && (wa[i] != i || wd[i] !== mem[i] || wc[i] != t0 + 2 + i)) bad = i;
        tests_run++;
        if (bad >= 0) begin
            tests_failed++;
            $display("FAIL %s write_seq: idx %0d got addr %0d data %0h cyc %0d expected %0d %0h %0d",
                     nm, bad, wa[bad], wd[bad], wc[bad], bad, mem[bad], t0 + 2 + bad);
        end
        tests_run++;
        if (c0n != 1 || c1n != 1 || c0c != s || c1c != s) begin
            tests_failed++;
            $display("FAIL %s start_pulse: got n=%0d/%0d cyc=%0d/%0d expected 1/1 at %0d",
                     nm, c0n, c1n, c0c - t0, c1c - t0, s - t0);
        end
        tests_run++;
        if (key !== ek || key_valid !== ev) begin
            tests_failed++;
            $display("FAIL %s result: got key %06h valid %b expected %06h %b",
                     nm, key, key_valid, ek, ev);
        end
        tests_run++;
        if (abn != int'(eab)) begin
            tests_failed++; $display("FAIL %s abort_cycles: got %0d expected %0d", nm, abn, eab);
        end
        tests_run++;
        if (tdone != edone) begin
            tests_failed++;
            $display("FAIL %s done_cycle: got %0d expected %0d", nm, tdone - t0, edone - t0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({rdy, key_valid, cp_wren, c0_en, c1_en, core_rst_n} !== 6'b100000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 100000",
                     {rdy, key_valid, cp_wren, c0_en, c1_en, core_rst_n});
        end
        tests_run++;
        if (key !== '0 || ct_addr !== '0 || cp_addr !== '0 || cp_wrdata !== '0) begin
            tests_failed++;
            $display("FAIL reset_buses: got key %0h ct %0h cp %0h wd %0h expected 0",
                     key, ct_addr, cp_addr, cp_wrdata);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (core_rst_n !== 1'b1 || rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release: got core_rst_n %b rdy %b expected 1 1", core_rst_n, rdy);
        end
    endtask

    task automatic test_directed();
        fill_mem(3);
        mem[1] = 8'hA1; mem[2] = 8'hB2; mem[3] = 8'hC3;
        run_op("c1_wins", 3, 0, 0, 20, 1, 24'h000100, 8, 1, 24'h00002B);
        fill_mem(5);
        run_op("tie", 5, 0, 0, 10, 1, 24'h000010, 10, 1, 24'h000011);
        fill_mem(4);
        run_op("none_valid", 4, 0, 0, 5, 0, 24'h000222, 55, 0, 24'h000333);
        fill_mem(6);
        run_op("c0_bad_c1_ok", 6, 0, 0, 3, 0, 24'h000444, 12, 1, 24'h000555);
    endtask

    task automatic test_length_bounds();
        fill_mem(0);
        run_op("len0", 0, 0, 0, 4, 1, 24'h000abc, 9, 0, 24'h0);
        fill_mem(255);
        run_op("len255", 255, 0, 0, 7, 0, 24'h0, 6, 1, 24'h123457);
    endtask

    task automatic test_start_wait();
        fill_mem(7);
        run_op("start_wait", 7, 6, 0, 5, 1, 24'h000808, 9, 1, 24'h000909);
    endtask

    task automatic test_busy_en();
        fill_mem(12);
        run_op("busy_en", 12, 0, 1, 15, 1, 24'h00aaaa, 6, 0, 24'h0);
    endtask

    task automatic test_reset_mid_copy();
        int n;
        fill_mem(20);
        @(posedge clk); #1; en = 1'b1;
        @(posedge clk); #1; en = 1'b0;
        n = 0;
        while (!(cp_wren === 1'b1 && cp_addr === 8'd5) && n < 40) begin
            @(posedge clk); #1; n++;
        end
        tests_run++;
        if (n >= 40) begin
            tests_failed++; $display("FAIL midrst_reach: write 5 not seen in %0d cycles", n);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (rdy !== 1'b1 || cp_wren !== 1'b0 || core_rst_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_state: got rdy %b wren %b core_rst_n %b expected 1 0 0",
                     rdy, cp_wren, core_rst_n);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill_mem(9);
        run_op("after_rst", 9, 0, 0, 8, 1, 24'h0000f0, 8, 0, 24'h0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            int len, d0, d1;
            logic [KEY_W-1:0] k0, k1;
            len = int'($urandom_range(0, 40));
            d0  = int'($urandom_range(1, 30));
            d1  = ($urandom_range(0, 3) == 0) ? d0 : int'($urandom_range(1, 30));
            k0  = KEY_W'($urandom) & ~KEY_W'(1);
            k1  = KEY_W'($urandom) | KEY_W'(1);
            fill_mem(len);
            run_op("random", len, int'($urandom_range(0, 3)), 1'($urandom), d0, 1'($urandom),
                   k0, d1, 1'($urandom), k1);
        end
    endtask

    initial begin
        fill_mem(0);
        test_reset();
        test_directed();
        test_length_bounds();
        test_start_wait();
        test_busy_en();
        test_reset_mid_copy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
